// File: rtl/toggle_hs_pkg.sv
// Shared types and defaults for the two-phase toggle handshake link.
package toggle_hs_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hs_state_t;

endpackage

// File: rtl/toggle_hs_rx_tgl_sync.sv
// SYNC_STAGES-deep single-bit synchronizer, synchronous active-low reset to 0.
// Used for req_tgl here and by the transmitter for ack_tgl.
module tgl_sync
    import toggle_hs_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_hs_rx.sv
// Receive side of the two-phase toggle link: sync req, capture word, valid/ready out, toggle ack.
// Optional sticky protocol-violation flag when TOGGLE_HS_RX_ERR_EN is defined.
//
// Downstream port: a word transfers at a posedge where out_valid & out_ready are both 1;
// out_valid/out_data never change while the word waits, and out_ready is ignored when out_valid=0.
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              dbg_state
`ifdef TOGGLE_HS_RX_ERR_EN
    ,
    output logic              proto_err
`endif
);

    hs_state_t         r_state;
    hs_state_t         w_state_nxt;
    logic              r_req_seen;
    logic              r_ack;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_req_s;
    logic              w_req_evt;
    logic              w_capture;
    logic              w_accept;

    tgl_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (req_tgl),
        .o_q  (w_req_s)
    );

    // Any parity difference means an unserviced toggle, however many toggles produced it.
    assign w_req_evt = w_req_s ^ r_req_seen;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_evt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_valid && out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_data     <= data_in;
                r_valid    <= 1'b1;
                r_req_seen <= w_req_s;
            end
            // Ack leaves on the accepting edge itself so the sender can launch the next word asap.
            if (w_accept) begin
                r_valid <= 1'b0;
                r_ack   <= ~r_ack;
            end
        end
    end

`ifdef TOGGLE_HS_RX_ERR_EN
    logic r_req_s_d;
    logic r_proto_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_req_s_d   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_req_s_d <= w_req_s;
            if (r_state == ST_HOLD && w_req_s != r_req_s_d) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err = r_proto_err;
`endif

    assign ack_tgl   = r_ack;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed + randomized bench for toggle_hs_rx: word scoreboard, ack parity model, latency checks.
module tb_toggle_hs_rx;
    import toggle_hs_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req_tgl = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ack_tgl;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         dbg_state;

    logic         req2 = 1'b0;
    logic [W-1:0] data2 = '0;
    logic         ack2;
    logic         valid2;
    logic [W-1:0] out2;
    logic         ready2 = 1'b1;
    logic         dbg2;
`ifdef TOGGLE_HS_RX_ERR_EN
    logic         proto_err;
    logic         proto_err2;
`endif

    toggle_hs_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_tgl   (req_tgl),
        .data_in   (data_in),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
`ifdef TOGGLE_HS_RX_ERR_EN
        ,
        .proto_err (proto_err)
`endif
    );

    toggle_hs_rx #(.DATA_W(W), .SYNC_STAGES(3)) dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .req_tgl   (req2),
        .data_in   (data2),
        .ack_tgl   (ack2),
        .out_valid (valid2),
        .out_data  (out2),
        .out_ready (ready2),
        .dbg_state (dbg2)
`ifdef TOGGLE_HS_RX_ERR_EN
        ,
        .proto_err (proto_err2)
`endif
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    int           acc_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter: one toggle launches one word.
    task automatic send(input logic [W-1:0] w);
        data_in = w;
        req_tgl = ~req_tgl;
        exp_q.push_back(w);
    endtask

    // Edges after the sampling edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] exp_front();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    task automatic accept_one(input string tag);
        out_ready = 1'b1;
        tick();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        acc_cnt++;
        chk({tag, "_ack"}, 32'(ack_tgl), 32'(acc_cnt & 1));
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'(0));
        out_ready = 1'b0;
    endtask

    task automatic xfer(input logic [W-1:0] w, input int bp);
        int lat;
        logic [W-1:0] exp_w;
        out_ready = 1'b0;
        send(w);
        wait_valid(lat);
        exp_w = exp_front();
        chk("latency", 32'(lat), 32'(2));
        chk("capture_data", 32'(out_data), 32'(exp_w));
        chk("state_hold", 32'(dbg_state), 32'(1));
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_data", 32'(out_data), 32'(exp_w));
            chk("bp_ack", 32'(ack_tgl), 32'(acc_cnt & 1));
        end
        accept_one("xfer");
        data_in = W'($urandom_range(0, 255));
        tick();
        chk("no_recapture", 32'(out_valid), 32'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int lat;
        logic [W-1:0] w1;
        logic [W-1:0] w2;

        // reset values
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_ack", 32'(ack_tgl), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_state", 32'(dbg_state), 32'(0));
        rstn = 1'b1;
        tick();

        // first word with out_ready already high: ack at the edge after valid rises
        out_ready = 1'b1;
        send(8'hA5);
        tick();
        chk("a5_valid_e0", 32'(out_valid), 32'(0));
        tick();
        chk("a5_valid_e1", 32'(out_valid), 32'(0));
        tick();
        chk("a5_valid_e2", 32'(out_valid), 32'(1));
        chk("a5_data", 32'(out_data), 32'(exp_front()));
        chk("a5_ack_before", 32'(ack_tgl), 32'(0));
        tick();
        void'(exp_q.pop_front());
        acc_cnt++;
        chk("a5_ack", 32'(ack_tgl), 32'(acc_cnt & 1));
        chk("a5_valid_drop", 32'(out_valid), 32'(0));
        out_ready = 1'b0;
        tick();

        // backpressure
        xfer(8'h3C, 10);

        // burst of four, each sent after ack observed
        for (int i = 1; i <= 4; i++) xfer(W'(i), 0);
        chk("burst_ack_end", 32'(ack_tgl), 32'(0));

        // randomized words and stall lengths
        for (int i = 0; i < 8; i++) xfer(W'($urandom_range(0, 255)), $urandom_range(0, 5));

        // three-stage synchronizer latency
        data2 = 8'hC3;
        req2 = ~req2;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid2) begin
                lat = i;
                break;
            end
        end
        chk("sync3_latency", 32'(lat), 32'(3));
        chk("sync3_data", 32'(out2), 32'(8'hC3));
        tick();
        chk("sync3_ack", 32'(ack2), 32'(1));

        // extra toggle while holding a word: re-captured after the handshake
        w1 = W'($urandom_range(0, 255));
        w2 = ~w1;
        send(w1);
        wait_valid(lat);
        chk("viol_latency", 32'(lat), 32'(2));
        send(w2);
        tick();
`ifdef TOGGLE_HS_RX_ERR_EN
        chk("perr_e0", 32'(proto_err), 32'(0));
`endif
        tick();
`ifdef TOGGLE_HS_RX_ERR_EN
        chk("perr_e1", 32'(proto_err), 32'(0));
`endif
        tick();
`ifdef TOGGLE_HS_RX_ERR_EN
        chk("perr_e2", 32'(proto_err), 32'(1));
`endif
        chk("viol_hold_data", 32'(out_data), 32'(w1));
        chk("viol_hold_valid", 32'(out_valid), 32'(1));
        accept_one("viol_first");
        tick();
        chk("viol_recap_valid", 32'(out_valid), 32'(1));
        chk("viol_recap_data", 32'(out_data), 32'(exp_front()));
        accept_one("viol_second");
`ifdef TOGGLE_HS_RX_ERR_EN
        tick();
        chk("perr_sticky", 32'(proto_err), 32'(1));
`endif

        // reset while a word is held
        send(8'h5A);
        wait_valid(lat);
        chk("mid_latency", 32'(lat), 32'(2));
        tick();
        rstn    = 1'b0;
        req_tgl = 1'b0;
        req2    = 1'b0;
        data_in = '0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_ack", 32'(ack_tgl), 32'(0));
        chk("mid_rst_data", 32'(out_data), 32'(0));
`ifdef TOGGLE_HS_RX_ERR_EN
        chk("perr_rst", 32'(proto_err), 32'(0));
`endif
        exp_q.delete();
        acc_cnt = 0;
        rstn = 1'b1;
        tick();
        xfer(W'($urandom_range(0, 255)), 2);
        chk("post_rst_ack", 32'(ack_tgl), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/toggle_hs_rx.md
Name: toggle_hs_rx

Overview:
Receiving end of the team's two-phase (toggle) request/acknowledge link. The transmitter toggles req_tgl with a T-type flop for every word. This block synchronizes the toggle and detects the change. It then captures data_in and presents the word downstream on a valid/ready port. After the downstream accepts the word, it toggles ack_tgl back to the transmitter. It sits at the destination side of any cross-block or cross-clock word transfer.

Parameters:
DATA_W, 8, width of data_in/out_data
SYNC_STAGES, 2, flop stages on req_tgl before edge detection; legal range 2..4

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
req_tgl  in  1  request toggle from transmitter; one toggle = one word
data_in  in  DATA_W  word from transmitter; held stable from req toggle until ack toggle observed
ack_tgl  out  1  acknowledge toggle to transmitter
out_valid  out  1  out_data holds an unconsumed word
out_data  out  DATA_W  captured word
out_ready  in  1  downstream accepts when out_valid & out_ready at posedge clk

Behaviour:
- Reset (synchronous, rstn low at posedge clk):
  - sync chain = 0, req_seen = 0, state = ST_IDLE
  - ack_tgl = 0, out_valid = 0, out_data = 0
  - The transmitter resets concurrently, so req_tgl = 0 after reset.
- Sync chain: req_tgl passes through SYNC_STAGES flops; req_s is the last stage.
- Toggle detection: req_evt = req_s ^ req_seen. req_seen is a register updated only on capture.
- States:
  - ST_IDLE, with req_evt = 1: out_data <= data_in, out_valid <= 1, req_seen <= req_s, next state ST_HOLD.
  - ST_IDLE, with req_evt = 0: hold.
  - ST_HOLD, with out_valid & out_ready: out_valid <= 0, ack_tgl <= ~ack_tgl, next state ST_IDLE.
  - ST_HOLD otherwise: out_data and out_valid hold; backpressure is unbounded.
- Latency:
  - A req_tgl change sampled at edge k gives req_s changed after edge k+SYNC_STAGES-1.
  - out_valid is high after edge k+SYNC_STAGES.
  - ack_tgl toggles at the same edge that completes the handshake. There is no added cycle.
- Throughput and ordering:
  - At most one word in flight.
  - No new capture in the cycle the handshake completes; state returns to ST_IDLE first.
  - Minimum spacing between captures is 2 cycles from the receiver side.
- out_ready while out_valid = 0: ignored.
- Extra req_tgl toggle while in ST_HOLD:
  - This is a protocol violation.
  - The toggle is not captured and req_seen is unchanged.
  - Because req_evt stays 1, the word is captured on return to ST_IDLE. The parity of the toggles determines this.
  - A double toggle is therefore invisible. See the optional feature.
- Reset mid-transfer: the word held in out_data is dropped and ack is not issued; both ends restart from 0.
- No arithmetic. All registers are DATA_W or 1 bit wide.

Optional Feature:
Macro: TOGGLE_HS_RX_ERR_EN
- Defined:
  - Adds output port proto_err (1 bit, reset 0).
  - proto_err is sticky: it sets at the first edge where state = ST_HOLD and req_s differs from its previous-cycle value.
  - It is cleared only by reset.
- Undefined: no port and no logic. Behaviour is otherwise identical.

Decomposition:
- Package toggle_hs_pkg:
  - state typedef hs_state_t {ST_IDLE, ST_HOLD}
  - constants DEF_DATA_W = 8 and DEF_SYNC_STAGES = 2
- Sub-module tgl_sync:
  - parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous active-low reset to 0
  - Instantiated once for req_tgl and reusable by the matching transmitter for ack_tgl.

Test Plan:
- Reset → out_valid = 0, ack_tgl = 0, out_data = 0. Then toggle req_tgl 0→1 with data_in = 8'hA5 and out_ready = 1:
  - out_valid rises 2 edges after the sampling edge (SYNC_STAGES = 2) with out_data = 8'hA5.
  - ack_tgl becomes 1 at that same handshake edge.
- Backpressure: capture 8'h3C with out_ready = 0 for 10 cycles.
  - out_valid and out_data stay stable and ack_tgl does not change.
  - Raise out_ready: one-cycle handshake, then ack_tgl toggles.
- Burst of 4 words (8'h01..8'h04), with the transmitter model toggling req only after it sees ack toggle:
  - All 4 arrive in order.
  - ack_tgl ends at 0 after 4 toggles.
- Reset mid-transfer: assert rstn = 0 while in ST_HOLD.
  - Next edge: out_valid = 0, ack_tgl = 0.
  - A fresh transfer afterwards completes normally.
- TOGGLE_HS_RX_ERR_EN defined: toggle req_tgl while out_valid = 1 and out_ready = 0.
  - proto_err = 1 two edges later and stays 1 until reset.
  - With the macro undefined, the same stimulus compiles without the port.
- SYNC_STAGES = 3: a single toggle gives out_valid 3 edges after the sampling edge.
